// File: rtl/bus_responder.sv
// Wait-state bus slave with a 256x8 storage array, rd/wr strobes and ready/err pulses.
// Define BUS_RESPONDER_WRPROT_EN to make 0x00..0x3F read-only (writes there complete with err).
module bus_responder #(
    parameter int WAIT = 1
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       ready,
    output logic       err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [2:0] LP_CNT_LOAD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

    logic [1:0] r_state;
    logic [2:0] r_cnt;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic       r_op_rd;
    logic       r_err;
    logic [7:0] r_data_out;
    logic [7:0] r_mem [256];

    logic [1:0] w_state_nxt;
    logic       w_start;
    logic       w_collide;
    logic       w_op_strobe;
    logic       w_enter_resp;
    logic [7:0] w_acc_addr;
    logic [7:0] w_acc_data;
    logic       w_acc_rd;
    logic       w_prot;
    logic       w_mem_we;
    logic       w_rd_load;

    assign w_start     = rd ^ wr;
    assign w_collide   = rd & wr;
    assign w_op_strobe = r_op_rd ? rd : wr;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_collide)
                    w_state_nxt = S_HOLD;
                else if (w_start)
                    w_state_nxt = (WAIT > 0) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                if (!w_op_strobe)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == 3'd0)
                    w_state_nxt = S_RESP;
            end
            S_RESP: w_state_nxt = (rd || wr) ? S_HOLD : S_IDLE;
            S_HOLD: begin
                if (!rd && !wr)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // With no wait states the access happens on the accepting edge, so use the live inputs.
    assign w_acc_addr   = (r_state == S_IDLE) ? addr    : r_addr;
    assign w_acc_data   = (r_state == S_IDLE) ? data_in : r_data;
    assign w_acc_rd     = (r_state == S_IDLE) ? rd      : r_op_rd;
    assign w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP) && !rst;

`ifdef BUS_RESPONDER_WRPROT_EN
    assign w_prot = (w_acc_addr[7:6] == 2'b00);
`else
    assign w_prot = 1'b0;
`endif

    assign w_mem_we  = w_enter_resp && !w_acc_rd && !w_prot;
    assign w_rd_load = w_enter_resp && w_acc_rd;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_op_rd    <= 1'b0;
            r_err      <= 1'b0;
            r_data_out <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_collide) begin
                        r_err   <= 1'b1;
                        r_op_rd <= 1'b0;
                    end else if (w_start) begin
                        r_op_rd <= rd;
                        r_cnt   <= LP_CNT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (w_state_nxt == S_IDLE)
                        r_cnt <= 3'd0;
                    else if (r_cnt != 3'd0)
                        r_cnt <= r_cnt - 3'd1;
                end
                default: ;
            endcase
            // A blocked write still completes; err rides alongside the ready pulse.
            if (w_enter_resp && !w_acc_rd && w_prot)
                r_err <= 1'b1;
            if (w_rd_load)
                r_data_out <= r_mem[w_acc_addr];
        end
    end

    always_ff @(posedge clk1) begin
        if ((r_state == S_IDLE) && w_start) begin
            r_addr <= addr;
            r_data <= data_in;
        end
    end

    always_ff @(posedge clk1) begin
        if (w_mem_we)
            r_mem[w_acc_addr] <= w_acc_data;
    end

    assign ready    = (r_state == S_RESP);
    assign data_oe  = r_op_rd && ((r_state == S_RESP) || (r_state == S_HOLD));
    assign err      = r_err;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_bus_responder.sv
// Randomized self-checking bench for bus_responder against an array-based storage model.
module tb_bus_responder;

    localparam int TB_WAIT = 1;

    logic       clk1 = 1'b0;
    logic       rst = 1'b1;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_oe;
    logic       ready;
    logic       err;

    bus_responder #(.WAIT(TB_WAIT)) dut (
        .clk1(clk1), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe), .ready(ready), .err(err)
    );

    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] model [256];
    logic [7:0] last_rd = 8'h00;

    int         o_lat, o_err_pre, o_oe_hold, o_extra;
    logic [7:0] o_dout;
    logic       o_oe_rdy, o_err_rdy, o_oe_after;

    function automatic logic is_prot(input logic [7:0] a);
`ifdef BUS_RESPONDER_WRPROT_EN
        return a < 8'h40;
`else
        return 1'b0;
`endif
    endfunction

    // Runs one access from IDLE and records what the bus showed; entered and left just after a negedge.
    task automatic access(input logic op_rd, input logic op_wr, input logic [7:0] a,
                          input logic [7:0] d, input int hold);
        o_lat = -1; o_dout = 8'h00; o_oe_rdy = 1'b0; o_err_rdy = 1'b0;
        o_err_pre = 0; o_oe_hold = 0; o_extra = 0;
        rd = op_rd; wr = op_wr; addr = a; data_in = d;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk1);
            if (ready) begin
                o_lat = k; o_dout = data_out; o_oe_rdy = data_oe; o_err_rdy = err;
                break;
            end
            if (err) o_err_pre++;
        end
        if (o_lat > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk1);
                if (data_oe) o_oe_hold++;
                if (ready || err) o_extra++;
            end
        end
        rd = 1'b0; wr = 1'b0;
        @(negedge clk1);
        o_oe_after = data_oe;
        if (ready || err) o_extra++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk1);
        @(negedge clk1);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", data_oe); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", data_out); end
        rst = 1'b0;
        last_rd = 8'h00;
    endtask

    task automatic test_fill;
        logic [7:0] a, d;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            d = 8'($urandom);
            access(1'b0, 1'b1, a, d, 0);
            n_checks++; if (o_lat !== TB_WAIT + 1) begin n_fail++; $display("FAIL fill_lat a=%h: got %0d expected %0d", a, o_lat, TB_WAIT + 1); end
            n_checks++; if (o_err_rdy !== is_prot(a)) begin n_fail++; $display("FAIL fill_err a=%h: got %b expected %b", a, o_err_rdy, is_prot(a)); end
            n_checks++; if (o_err_pre + o_extra !== 0) begin n_fail++; $display("FAIL fill_stray a=%h: got %0d expected 0", a, o_err_pre + o_extra); end
            n_checks++; if (data_out !== last_rd) begin n_fail++; $display("FAIL fill_dout_hold a=%h: got %h expected %h", a, data_out, last_rd); end
            if (is_prot(a)) begin
                // Protected locations were never written, so their power-up content becomes the baseline.
                access(1'b1, 1'b0, a, 8'h00, 0);
                model[a] = o_dout;
                last_rd = o_dout;
            end else begin
                model[a] = d;
            end
        end
    endtask

    task automatic test_directed;
        logic [7:0] exp5;
        access(1'b0, 1'b1, 8'h80, 8'h5A, 0);
        model[8'h80] = 8'h5A;
        n_checks++; if (o_lat !== TB_WAIT + 1) begin n_fail++; $display("FAIL dir_wr80_lat: got %0d expected %0d", o_lat, TB_WAIT + 1); end
        access(1'b1, 1'b0, 8'h80, 8'h00, 2);
        n_checks++; if (o_lat !== TB_WAIT + 1) begin n_fail++; $display("FAIL dir_rd80_lat: got %0d expected %0d", o_lat, TB_WAIT + 1); end
        n_checks++; if (o_dout !== 8'h5A) begin n_fail++; $display("FAIL dir_rd80_data: got %h expected 5a", o_dout); end
        n_checks++; if (o_oe_rdy !== 1'b1 || o_oe_hold !== 2) begin n_fail++; $display("FAIL dir_rd80_oe: got %b/%0d expected 1/2", o_oe_rdy, o_oe_hold); end
        n_checks++; if (o_oe_after !== 1'b0) begin n_fail++; $display("FAIL dir_rd80_oe_drop: got %b expected 0", o_oe_after); end
        access(1'b0, 1'b1, 8'hFF, 8'hC3, 0);
        model[8'hFF] = 8'hC3;
        access(1'b1, 1'b0, 8'hFF, 8'h00, 0);
        n_checks++; if (o_dout !== 8'hC3) begin n_fail++; $display("FAIL dir_rdff_data: got %h expected c3", o_dout); end
        exp5 = is_prot(8'h05) ? model[8'h05] : 8'hAA;
        access(1'b0, 1'b1, 8'h05, 8'hAA, 0);
        n_checks++; if (o_lat !== TB_WAIT + 1 || o_err_rdy !== is_prot(8'h05)) begin n_fail++; $display("FAIL dir_wr05: got lat %0d err %b expected lat %0d err %b", o_lat, o_err_rdy, TB_WAIT + 1, is_prot(8'h05)); end
        model[8'h05] = exp5;
        access(1'b1, 1'b0, 8'h05, 8'h00, 0);
        n_checks++; if (o_dout !== exp5) begin n_fail++; $display("FAIL dir_rd05_data: got %h expected %h", o_dout, exp5); end
        last_rd = exp5;
    endtask

    task automatic test_random_rw;
        logic [7:0] a, d;
        logic       op_rd;
        int         hold;
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            op_rd = 1'($urandom);
            hold = int'($urandom_range(0, 3));
            access(op_rd, !op_rd, a, d, hold);
            n_checks++; if (o_lat !== TB_WAIT + 1) begin n_fail++; $display("FAIL rand_lat a=%h rd=%b: got %0d expected %0d", a, op_rd, o_lat, TB_WAIT + 1); end
            n_checks++; if (o_err_pre + o_extra !== 0) begin n_fail++; $display("FAIL rand_stray a=%h: got %0d expected 0", a, o_err_pre + o_extra); end
            n_checks++; if (o_oe_hold !== (op_rd ? hold : 0)) begin n_fail++; $display("FAIL rand_oe_hold a=%h: got %0d expected %0d", a, o_oe_hold, op_rd ? hold : 0); end
            if (op_rd) begin
                n_checks++; if (o_dout !== model[a]) begin n_fail++; $display("FAIL rand_rd_data a=%h: got %h expected %h", a, o_dout, model[a]); end
                n_checks++; if (o_oe_rdy !== 1'b1 || o_err_rdy !== 1'b0) begin n_fail++; $display("FAIL rand_rd_flags a=%h: got oe %b err %b expected 1 0", a, o_oe_rdy, o_err_rdy); end
                last_rd = model[a];
            end else begin
                n_checks++; if (o_err_rdy !== is_prot(a) || o_oe_rdy !== 1'b0) begin n_fail++; $display("FAIL rand_wr_flags a=%h: got err %b oe %b expected %b 0", a, o_err_rdy, o_oe_rdy, is_prot(a)); end
                if (!is_prot(a)) model[a] = d;
            end
            n_checks++; if (o_oe_after !== 1'b0 || data_out !== last_rd) begin n_fail++; $display("FAIL rand_after a=%h: got oe %b dout %h expected 0 %h", a, o_oe_after, data_out, last_rd); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] a, d;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            access(1'b0, 1'b1, a, d, 0);
            if (!is_prot(a)) model[a] = d;
            access(1'b1, 1'b0, a, 8'h00, 0);
            n_checks++; if (o_lat !== TB_WAIT + 1 || o_dout !== model[a]) begin n_fail++; $display("FAIL b2b a=%h: got lat %0d data %h expected %0d %h", a, o_lat, o_dout, TB_WAIT + 1, model[a]); end
            last_rd = model[a];
        end
    endtask

    task automatic test_abort;
        logic [7:0] a, d;
        logic       op_rd;
        int         n, stray;
        for (int i = 0; i < 12; i++) begin
            a = 8'($urandom);
            d = ~model[a];
            op_rd = 1'($urandom);
            n = int'($urandom_range(1, TB_WAIT));
            rd = op_rd; wr = !op_rd; addr = a; data_in = d;
            for (int k = 0; k < n; k++) @(negedge clk1);
            rd = 1'b0; wr = 1'b0;
            stray = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk1);
                if (ready || err || data_oe) stray++;
            end
            n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL abort_stray a=%h rd=%b: got %0d expected 0", a, op_rd, stray); end
            n_checks++; if (data_out !== last_rd) begin n_fail++; $display("FAIL abort_dout a=%h: got %h expected %h", a, data_out, last_rd); end
            access(1'b1, 1'b0, a, 8'h00, 0);
            n_checks++; if (o_dout !== model[a]) begin n_fail++; $display("FAIL abort_mem a=%h: got %h expected %h", a, o_dout, model[a]); end
            last_rd = model[a];
        end
    endtask

    task automatic test_collision;
        logic [7:0] a;
        int         stray;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom);
            rd = 1'b1; wr = 1'b1; addr = a; data_in = ~model[a];
            @(negedge clk1);
            n_checks++; if (err !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL coll_pulse a=%h: got err %b ready %b expected 1 0", a, err, ready); end
            stray = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk1);
                if (ready || err || data_oe) stray++;
            end
            wr = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk1);
                if (ready || err || data_oe) stray++;
            end
            rd = 1'b0;
            @(negedge clk1);
            n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL coll_hold a=%h: got %0d expected 0", a, stray); end
            access(1'b1, 1'b0, a, 8'h00, 0);
            n_checks++; if (o_lat !== TB_WAIT + 1 || o_dout !== model[a]) begin n_fail++; $display("FAIL coll_after a=%h: got lat %0d data %h expected %0d %h", a, o_lat, o_dout, TB_WAIT + 1, model[a]); end
            last_rd = model[a];
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] pre;
        pre = 8'h00;
        for (int i = 0; i < 256; i++) if (model[i] != 8'h00) pre = 8'(i);
        access(1'b1, 1'b0, pre, 8'h00, 0);
        last_rd = model[pre];
        wr = 1'b1; addr = 8'h20; data_in = ~model[8'h20];
        @(negedge clk1);
        rst = 1'b1; wr = 1'b0;
        @(negedge clk1);
        n_checks++; if ({ready, err, data_oe, data_out} !== 11'd0) begin n_fail++; $display("FAIL rstmid_outs: got %b%b%b %h expected all 0", ready, err, data_oe, data_out); end
        rst = 1'b0;
        last_rd = 8'h00;
        access(1'b1, 1'b0, 8'h20, 8'h00, 0);
        n_checks++; if (o_lat !== TB_WAIT + 1 || o_dout !== model[8'h20]) begin n_fail++; $display("FAIL rstmid_mem: got lat %0d data %h expected %0d %h", o_lat, o_dout, TB_WAIT + 1, model[8'h20]); end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_directed;
        test_random_rw;
        test_back_to_back;
        test_abort;
        test_collision;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
